// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared decode, branch and hazard types for the dual-issue pipeline controller.
package pipeline_pkg;

   typedef enum logic [1:0] {RUN, FLUSH, HALT} ctrl_state_e;

   typedef enum logic [1:0] {ALU_TYPE, MEM_TYPE, BR_TYPE, SYS_TYPE} instr_type_e;

   typedef struct packed {
      logic        valid;
      instr_type_e itype;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic        use_rs1;
      logic        use_rs2;
      logic        wren;
      logic        load_en;
      logic        store_en;
      logic        prd_en;
      logic        ecall;
      logic        ebreak;
   } decode_t;

   typedef struct packed {
      logic        br_update_en;
      logic        br_valid;
      logic        br_taken;
      logic        br_already_predicted;
      logic [31:0] br_target;
      logic [31:0] br_pc_plus4;
   } branch_t;

   typedef struct packed {
      logic issue_u;
      logic issue_v;
      logic split;
      logic stall_f;
      logic stall_d;
      logic flush_f;
      logic flush_d;
   } hazard_t;

   // x0 never creates a dependency
   function automatic logic reads_reg(decode_t d, logic [4:0] r);
      return (r != 5'd0) && ((d.use_rs1 && d.rs1_addr == r) || (d.use_rs2 && d.rs2_addr == r));
   endfunction

endpackage

// File: rtl/issue_pair_check.sv
// issue_pair_check: decides whether slot V may pair with slot U in the same cycle.
module issue_pair_check
   import pipeline_pkg::*;
(
   input  logic    en,
   input  decode_t dec_u,
   input  decode_t dec_v,
   output logic    issue_v
);

   logic v_simple;
   logic raw;

   assign v_simple = dec_v.valid & ~dec_v.load_en & ~dec_v.store_en & ~dec_v.prd_en & (dec_v.itype != SYS_TYPE);
   assign raw      = dec_u.wren & reads_reg(dec_v, dec_u.rd_addr);
   assign issue_v  = en & v_simple & ~raw;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: issue, stall, flush and redirect control for a two-slot (U/V) in-order pipeline.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  decode_t     i_dec_u,
   input  decode_t     i_dec_v,
   input  branch_t     i_branch,
   input  logic        i_resume,
   output logic        o_issue_u,
   output logic        o_issue_v,
   output logic        o_split,
   output logic        o_stall_fetch,
   output logic        o_stall_decode,
   output logic        o_flush_fetch,
   output logic        o_flush_decode,
   output logic        o_redirect_en,
   output logic [31:0] o_redirect_pc,
   output logic        o_halted,
   output logic [31:0] o_bubble_cnt
);

   ctrl_state_e state, state_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic        ld_pend;
   logic [4:0]  ld_rd;
   hazard_t     hz;
   logic        redirect;
   logic        mispredict;
   logic        load_use;
   logic        u_sys;
   logic        pair_ok;

   assign mispredict = i_branch.br_update_en & i_branch.br_valid & (i_branch.br_taken ^ i_branch.br_already_predicted);
   assign load_use   = ld_pend & reads_reg(i_dec_u, ld_rd);
   assign u_sys      = i_dec_u.ecall | i_dec_u.ebreak;

   issue_pair_check u_pair (
      .en      (~u_sys),
      .dec_u   (i_dec_u),
      .dec_v   (i_dec_v),
      .issue_v (pair_ok)
   );

   // a halting instruction still issues even if it would also see load-use
   always_comb begin
      hz        = '0;
      redirect  = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;
      if (mispredict) begin
         redirect   = 1'b1;
         hz.flush_f = 1'b1;
         hz.flush_d = 1'b1;
         state_nxt  = FLUSH;
         cnt_nxt    = 3'(FLUSH_CYCLES);
      end else if (state == FLUSH) begin
         hz.flush_f = 1'b1;
         hz.flush_d = 1'b1;
         cnt_nxt    = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
         state_nxt  = (cnt <= 3'd1) ? RUN : FLUSH;
      end else if (state == HALT) begin
         hz.stall_f = 1'b1;
         hz.stall_d = 1'b1;
         state_nxt  = i_resume ? RUN : HALT;
      end else if (i_dec_u.valid && (u_sys || !load_use)) begin
         hz.issue_u = 1'b1;
         hz.issue_v = pair_ok;
         hz.split   = i_dec_v.valid & ~pair_ok;
         hz.stall_f = i_dec_v.valid & ~pair_ok;
         state_nxt  = u_sys ? HALT : RUN;
      end else if (i_dec_u.valid) begin
         hz.stall_f = 1'b1;
         hz.stall_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= RUN;
         cnt          <= 3'd0;
         ld_pend      <= 1'b0;
         ld_rd        <= 5'd0;
         o_bubble_cnt <= 32'd0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ld_pend <= hz.issue_u & i_dec_u.load_en;
         if (hz.issue_u && i_dec_u.load_en)
            ld_rd <= i_dec_u.rd_addr;
         if (state == RUN && i_dec_u.valid && !hz.issue_u && o_bubble_cnt != 32'hFFFF_FFFF)
            o_bubble_cnt <= o_bubble_cnt + 32'd1;
      end
   end

   assign o_issue_u      = ~i_reset & hz.issue_u;
   assign o_issue_v      = ~i_reset & hz.issue_v;
   assign o_split        = ~i_reset & hz.split;
   assign o_stall_fetch  = ~i_reset & hz.stall_f;
   assign o_stall_decode = ~i_reset & hz.stall_d;
   assign o_flush_fetch  = ~i_reset & hz.flush_f;
   assign o_flush_decode = ~i_reset & hz.flush_d;
   assign o_redirect_en  = ~i_reset & redirect;
   assign o_redirect_pc  = o_redirect_en ? (i_branch.br_taken ? i_branch.br_target : i_branch.br_pc_plus4) : 32'd0;
   assign o_halted       = ~i_reset & (state == HALT);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of issue pairing, load-use, mispredict flush, halt and reset.
module tb_pipeline_ctrl;
   import pipeline_pkg::*;

   localparam int FC = 1;

   logic        i_clk;
   logic        i_reset;
   decode_t     i_dec_u;
   decode_t     i_dec_v;
   branch_t     i_branch;
   logic        i_resume;
   logic        o_issue_u, o_issue_v, o_split;
   logic        o_stall_fetch, o_stall_decode;
   logic        o_flush_fetch, o_flush_decode;
   logic        o_redirect_en;
   logic [31:0] o_redirect_pc;
   logic        o_halted;
   logic [31:0] o_bubble_cnt;
   logic [8:0]  obs;
   int          checks;
   int          failures;

   pipeline_ctrl #(.FLUSH_CYCLES(FC)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_dec_u        (i_dec_u),
      .i_dec_v        (i_dec_v),
      .i_branch       (i_branch),
      .i_resume       (i_resume),
      .o_issue_u      (o_issue_u),
      .o_issue_v      (o_issue_v),
      .o_split        (o_split),
      .o_stall_fetch  (o_stall_fetch),
      .o_stall_decode (o_stall_decode),
      .o_flush_fetch  (o_flush_fetch),
      .o_flush_decode (o_flush_decode),
      .o_redirect_en  (o_redirect_en),
      .o_redirect_pc  (o_redirect_pc),
      .o_halted       (o_halted),
      .o_bubble_cnt   (o_bubble_cnt)
   );

   // bit order: issue_u issue_v split stall_f stall_d flush_f flush_d redirect_en halted
   assign obs = {o_issue_u, o_issue_v, o_split, o_stall_fetch, o_stall_decode,
                 o_flush_fetch, o_flush_decode, o_redirect_en, o_halted};

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic decode_t op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u2, input logic ld, input logic ec, input logic eb);
      decode_t d;
      d          = '0;
      d.valid    = 1'b1;
      d.rd_addr  = rd;
      d.rs1_addr = rs1;
      d.rs2_addr = rs2;
      d.use_rs1  = !(ec || eb);
      d.use_rs2  = u2;
      d.wren     = !(ec || eb);
      d.load_en  = ld;
      d.ecall    = ec;
      d.ebreak   = eb;
      d.itype    = (ec || eb) ? SYS_TYPE : (ld ? MEM_TYPE : ALU_TYPE);
      return d;
   endfunction

   function automatic decode_t addi(input logic [4:0] rd, input logic [4:0] rs1);
      return op(rd, rs1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic decode_t add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return op(rd, rs1, rs2, 1'b1, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic decode_t lw(input logic [4:0] rd, input logic [4:0] rs1);
      return op(rd, rs1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
   endfunction

   function automatic branch_t br(input logic taken, input logic pred, input logic [31:0] tgt, input logic [31:0] pc4);
      branch_t b;
      b.br_update_en         = 1'b1;
      b.br_valid             = 1'b1;
      b.br_taken             = taken;
      b.br_already_predicted = pred;
      b.br_target            = tgt;
      b.br_pc_plus4          = pc4;
      return b;
   endfunction

   task automatic clear_inputs();
      i_dec_u  = '0;
      i_dec_v  = '0;
      i_branch = '0;
      i_resume = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_reset = 1'b1;
      clear_inputs();
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   task automatic test_reset();
      i_reset  = 1'b1;
      i_dec_u  = addi(5'd5, 5'd1);
      i_dec_v  = addi(5'd6, 5'd2);
      i_branch = br(1'b1, 1'b0, 32'h100, 32'h44);
      i_resume = 1'b0;
      #1;
      checks++; if (obs !== 9'b0) begin failures++; $display("FAIL reset_outs obs=%b exp=%b", obs, 9'b0); end
      checks++; if (o_redirect_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", o_redirect_pc); end
      checks++; if (o_bubble_cnt !== 32'd0) begin failures++; $display("FAIL reset_bubble got=%0d exp=0", o_bubble_cnt); end
      @(negedge i_clk);
      i_reset = 1'b0;
      clear_inputs();
   endtask

   task automatic test_pairing();
      do_reset();
      @(negedge i_clk); i_dec_u = addi(5'd5, 5'd1); i_dec_v = add(5'd6, 5'd5, 5'd1); #1;
      checks++; if (obs !== 9'b101100000) begin failures++; $display("FAIL pair_raw obs=%b exp=%b", obs, 9'b101100000); end
      @(negedge i_clk); i_dec_v = addi(5'd6, 5'd2); #1;
      checks++; if (obs !== 9'b110000000) begin failures++; $display("FAIL pair_indep obs=%b exp=%b", obs, 9'b110000000); end
      @(negedge i_clk); i_dec_v = lw(5'd6, 5'd2); #1;
      checks++; if (obs !== 9'b101100000) begin failures++; $display("FAIL pair_v_load obs=%b exp=%b", obs, 9'b101100000); end
      @(negedge i_clk); i_dec_u = addi(5'd0, 5'd1); i_dec_v = add(5'd6, 5'd0, 5'd1); #1;
      checks++; if (obs !== 9'b110000000) begin failures++; $display("FAIL pair_x0 obs=%b exp=%b", obs, 9'b110000000); end
      @(negedge i_clk); i_dec_u = '0; i_dec_v = addi(5'd6, 5'd2); #1;
      checks++; if (obs !== 9'b000000000) begin failures++; $display("FAIL pair_lone_v obs=%b exp=%b", obs, 9'b0); end
   endtask

   task automatic test_load_use();
      do_reset();
      @(negedge i_clk); i_dec_u = lw(5'd7, 5'd1); #1;
      checks++; if (obs !== 9'b100000000) begin failures++; $display("FAIL lu_load obs=%b exp=%b", obs, 9'b100000000); end
      @(negedge i_clk); i_dec_u = add(5'd8, 5'd7, 5'd2); #1;
      checks++; if (obs !== 9'b000110000) begin failures++; $display("FAIL lu_stall obs=%b exp=%b", obs, 9'b000110000); end
      checks++; if (o_bubble_cnt !== 32'd0) begin failures++; $display("FAIL lu_bubble0 got=%0d exp=0", o_bubble_cnt); end
      @(negedge i_clk); #1;
      checks++; if (obs !== 9'b100000000) begin failures++; $display("FAIL lu_release obs=%b exp=%b", obs, 9'b100000000); end
      checks++; if (o_bubble_cnt !== 32'd1) begin failures++; $display("FAIL lu_bubble1 got=%0d exp=1", o_bubble_cnt); end
      @(negedge i_clk); i_dec_u = lw(5'd0, 5'd1); #1;
      @(negedge i_clk); i_dec_u = add(5'd8, 5'd0, 5'd2); #1;
      checks++; if (obs !== 9'b100000000) begin failures++; $display("FAIL lu_x0 obs=%b exp=%b", obs, 9'b100000000); end
   endtask

   task automatic test_mispredict();
      do_reset();
      @(negedge i_clk); i_dec_u = addi(5'd5, 5'd1); i_branch = br(1'b1, 1'b0, 32'h100, 32'h44); #1;
      checks++; if (obs !== 9'b000001110) begin failures++; $display("FAIL mp_taken obs=%b exp=%b", obs, 9'b000001110); end
      checks++; if (o_redirect_pc !== 32'h100) begin failures++; $display("FAIL mp_taken_pc got=%h exp=100", o_redirect_pc); end
      for (int k = 0; k < FC; k++) begin
         @(negedge i_clk); i_branch = '0; #1;
         checks++; if (obs !== 9'b000001100) begin failures++; $display("FAIL mp_flush obs=%b exp=%b", obs, 9'b000001100); end
         checks++; if (o_redirect_pc !== 32'd0) begin failures++; $display("FAIL mp_flush_pc got=%h exp=0", o_redirect_pc); end
      end
      @(negedge i_clk); #1;
      checks++; if (obs !== 9'b100000000) begin failures++; $display("FAIL mp_resume obs=%b exp=%b", obs, 9'b100000000); end
      @(negedge i_clk); i_branch = br(1'b0, 1'b1, 32'h200, 32'h44); #1;
      checks++; if (o_redirect_pc !== 32'h44 || obs !== 9'b000001110) begin failures++; $display("FAIL mp_nottaken pc=%h obs=%b exp pc=44 obs=%b", o_redirect_pc, obs, 9'b000001110); end
      for (int k = 0; k < FC; k++) begin
         @(negedge i_clk); i_branch = '0; #1;
      end
      @(negedge i_clk); i_branch = br(1'b1, 1'b1, 32'h200, 32'h44); #1;
      checks++; if (obs !== 9'b100000000 || o_redirect_pc !== 32'd0) begin failures++; $display("FAIL mp_correct obs=%b pc=%h exp obs=%b pc=0", obs, o_redirect_pc, 9'b100000000); end
   endtask

   task automatic test_halt();
      do_reset();
      @(negedge i_clk); i_dec_u = op(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); i_dec_v = addi(5'd6, 5'd2); #1;
      checks++; if (obs !== 9'b101100000) begin failures++; $display("FAIL halt_ecall obs=%b exp=%b", obs, 9'b101100000); end
      @(negedge i_clk); i_dec_u = addi(5'd6, 5'd2); i_dec_v = '0; #1;
      checks++; if (obs !== 9'b000110001) begin failures++; $display("FAIL halt_enter obs=%b exp=%b", obs, 9'b000110001); end
      @(negedge i_clk); #1;
      checks++; if (obs !== 9'b000110001) begin failures++; $display("FAIL halt_hold obs=%b exp=%b", obs, 9'b000110001); end
      @(negedge i_clk); i_resume = 1'b1; #1;
      checks++; if (obs !== 9'b000110001) begin failures++; $display("FAIL halt_resume_cyc obs=%b exp=%b", obs, 9'b000110001); end
      @(negedge i_clk); i_resume = 1'b0; #1;
      checks++; if (obs !== 9'b100000000) begin failures++; $display("FAIL halt_run obs=%b exp=%b", obs, 9'b100000000); end
   endtask

   task automatic test_coincident();
      do_reset();
      @(negedge i_clk); i_dec_u = lw(5'd7, 5'd1); #1;
      @(negedge i_clk); i_dec_u = add(5'd8, 5'd7, 5'd2); i_branch = br(1'b1, 1'b0, 32'h300, 32'h48); #1;
      checks++; if (obs !== 9'b000001110 || o_redirect_pc !== 32'h300) begin failures++; $display("FAIL co_lu obs=%b pc=%h exp obs=%b pc=300", obs, o_redirect_pc, 9'b000001110); end
      for (int k = 0; k < FC; k++) begin
         @(negedge i_clk); i_branch = '0; #1;
      end
      @(negedge i_clk); #1;
      checks++; if (obs !== 9'b100000000) begin failures++; $display("FAIL co_ldpend obs=%b exp=%b", obs, 9'b100000000); end
      @(negedge i_clk); i_dec_u = op(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); i_branch = br(1'b1, 1'b0, 32'h400, 32'h4c); #1;
      checks++; if (obs !== 9'b000001110) begin failures++; $display("FAIL co_ebreak obs=%b exp=%b", obs, 9'b000001110); end
      @(negedge i_clk); i_dec_u = '0; i_branch = '0; #1;
      checks++; if (obs !== 9'b000001100) begin failures++; $display("FAIL co_nohalt obs=%b exp=%b", obs, 9'b000001100); end
      for (int k = 1; k < FC; k++) begin
         @(negedge i_clk); #1;
      end
      @(negedge i_clk); i_dec_u = op(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
      @(negedge i_clk); i_dec_u = '0; #1;
      checks++; if (obs !== 9'b000110001) begin failures++; $display("FAIL co_halted obs=%b exp=%b", obs, 9'b000110001); end
      @(negedge i_clk); i_branch = br(1'b1, 1'b0, 32'h500, 32'h50); #1;
      checks++; if ((obs & 9'b111001110) !== 9'b000001110 || o_redirect_pc !== 32'h500) begin failures++; $display("FAIL co_halt_mp obs=%b pc=%h exp masked=%b pc=500", obs, o_redirect_pc, 9'b000001110); end
      @(negedge i_clk); i_branch = '0; #1;
      checks++; if (obs !== 9'b000001100) begin failures++; $display("FAIL co_halt_abandon obs=%b exp=%b", obs, 9'b000001100); end
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      @(negedge i_clk); i_dec_u = addi(5'd5, 5'd1); i_branch = br(1'b1, 1'b0, 32'h600, 32'h54); #1;
      @(negedge i_clk); i_branch = '0; #1;
      checks++; if (obs !== 9'b000001100) begin failures++; $display("FAIL rmf_flush obs=%b exp=%b", obs, 9'b000001100); end
      #1; i_reset = 1'b1; i_branch = br(1'b1, 1'b0, 32'h600, 32'h54); #1;
      checks++; if (obs !== 9'b0 || o_redirect_pc !== 32'd0) begin failures++; $display("FAIL rmf_zero obs=%b pc=%h exp obs=0 pc=0", obs, o_redirect_pc); end
      @(negedge i_clk); i_reset = 1'b0; i_branch = '0; #1;
      checks++; if (obs !== 9'b100000000) begin failures++; $display("FAIL rmf_run obs=%b exp=%b", obs, 9'b100000000); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_pairing();
      test_load_use();
      test_mispredict();
      test_halt();
      test_coincident();
      test_reset_mid_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
